// File: rtl/cam_2.sv
// Small fully-associative CAM: addressed writes, parallel tag lookup with registered data/hit.
// Optional same-cycle write-to-lookup forwarding when CAM2_WRITE_BYPASS_EN is defined.
module cam_2 #(
  parameter int BITS   = 8,
  parameter int TAG_SZ = 8,
  parameter int WORDS  = 8,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              read,
  input  logic [TAG_SZ-1:0] check_tag,
  output logic [BITS-1:0]   data,
  output logic              found_it,
  input  logic              write_,
  input  logic [AW-1:0]     w_addr,
  input  logic [BITS-1:0]   wdata,
  input  logic [TAG_SZ-1:0] new_tag,
  input  logic              new_valid
);

  logic [TAG_SZ-1:0] tag_mem  [WORDS];
  logic [BITS-1:0]   data_mem [WORDS];
  logic              val_mem  [WORDS];

  logic [WORDS-1:0]  match;
  logic              hit_any;
  logic [BITS-1:0]   hit_data;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_match
`ifdef CAM2_WRITE_BYPASS_EN
      // The entry being written is replaced by the forwarded write below.
      assign match[gi] = val_mem[gi] && (tag_mem[gi] == check_tag)
                         && !(!write_ && (w_addr == AW'(gi)));
`else
      assign match[gi] = val_mem[gi] && (tag_mem[gi] == check_tag);
`endif
    end
  endgenerate

  // Scan high to low so the lowest matching index is the last assignment.
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_any  = 1'b1;
        hit_data = data_mem[i];
      end
    end
`ifdef CAM2_WRITE_BYPASS_EN
    if (!write_ && new_valid && (new_tag == check_tag)) begin
      hit_any  = 1'b1;
      hit_data = wdata;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < WORDS; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
        val_mem[i]  <= 1'b0;
      end
    end else if (!write_) begin
      tag_mem[w_addr]  <= new_tag;
      data_mem[w_addr] <= wdata;
      val_mem[w_addr]  <= new_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data     <= '0;
      found_it <= 1'b0;
    end else if (read) begin
      data     <= hit_data;
      found_it <= hit_any;
    end else begin
      data     <= '0;
      found_it <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_2.sv
// Directed-vector bench for cam_2; define CAM2_WRITE_BYPASS_EN to check the forwarding build.
module tb_cam_2;
  logic       clk = 1'b0;
  logic       rst_;
  logic       read;
  logic [7:0] check_tag;
  logic [7:0] data;
  logic       found_it;
  logic       write_;
  logic [2:0] w_addr;
  logic [7:0] wdata;
  logic [7:0] new_tag;
  logic       new_valid;

  int n_checks = 0;
  int n_errors = 0;

  cam_2 #(.BITS(8), .TAG_SZ(8), .WORDS(8)) dut (
    .clk(clk), .rst_(rst_), .read(read), .check_tag(check_tag),
    .data(data), .found_it(found_it), .write_(write_), .w_addr(w_addr),
    .wdata(wdata), .new_tag(new_tag), .new_valid(new_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [7:0] t,
                             input logic [7:0] d, input logic v);
    read = 1'b0; write_ = 1'b0; w_addr = a; new_tag = t; wdata = d; new_valid = v;
    @(posedge clk); #1;
    write_ = 1'b1;
    $display("write addr=%0d tag=%02h data=%02h valid=%0b", a, t, d, v);
  endtask

  task automatic lookup(input string nm, input logic [7:0] t,
                        input logic ef, input logic [7:0] ed);
    read = 1'b1; write_ = 1'b1; check_tag = t;
    @(posedge clk); #1;
    read = 1'b0;
    $display("lookup %s tag=%02h found=%0b data=%02h", nm, t, found_it, data);
    check({nm, "_found"}, 32'(found_it), 32'(ef));
    check({nm, "_data"}, 32'(data), 32'(ed));
  endtask

  initial begin
    rst_ = 1'b0; read = 1'b0; write_ = 1'b1; check_tag = 8'h00;
    w_addr = '0; wdata = 8'h00; new_tag = 8'h00; new_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_found", 32'(found_it), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    #2 rst_ = 1'b1;

    lookup("empty_tag00", 8'h00, 1'b0, 8'h00);

    write_entry(3'd1, 8'h05, 8'h11, 1'b1);
    write_entry(3'd3, 8'h06, 8'h13, 1'b1);
    // Tag 1 is presented while write_ is high, so it must never be stored.
    read = 1'b0; write_ = 1'b1; w_addr = 3'd0; new_tag = 8'h01; wdata = 8'h99; new_valid = 1'b1;
    @(posedge clk); #1;
    $display("idle addr=0 tag=01 write_=1");
    write_entry(3'd5, 8'h00, 8'h15, 1'b1);
    write_entry(3'd6, 8'h04, 8'h16, 1'b1);
    write_entry(3'd7, 8'h09, 8'h17, 1'b1);

    lookup("hit05", 8'h05, 1'b1, 8'h11);
    lookup("hit06", 8'h06, 1'b1, 8'h13);
    lookup("hit00", 8'h00, 1'b1, 8'h15);
    lookup("hit04", 8'h04, 1'b1, 8'h16);
    lookup("hit09", 8'h09, 1'b1, 8'h17);
    lookup("miss07", 8'h07, 1'b0, 8'h00);
    lookup("miss01", 8'h01, 1'b0, 8'h00);

    write_entry(3'd2, 8'h05, 8'h22, 1'b1);
    lookup("dup_lowest", 8'h05, 1'b1, 8'h11);
    write_entry(3'd1, 8'h05, 8'h11, 1'b0);
    lookup("dup_after_inval", 8'h05, 1'b1, 8'h22);

    // Same-cycle write and lookup of a new tag.
    read = 1'b1; check_tag = 8'h0A;
    write_ = 1'b0; w_addr = 3'd4; new_tag = 8'h0A; wdata = 8'h55; new_valid = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write_ = 1'b1;
    $display("lookup+write tag=0a found=%0b data=%02h", found_it, data);
`ifdef CAM2_WRITE_BYPASS_EN
    check("rw_same_found", 32'(found_it), 32'd1);
    check("rw_same_data", 32'(data), 32'h55);
`else
    check("rw_same_found", 32'(found_it), 32'd0);
    check("rw_same_data", 32'(data), 32'h00);
`endif
    lookup("rw_next", 8'h0A, 1'b1, 8'h55);

    // Idle edge clears the registered result.
    @(posedge clk); #1;
    $display("idle read=0 found=%0b data=%02h", found_it, data);
    check("idle_found", 32'(found_it), 32'd0);
    check("idle_data", 32'(data), 32'd0);

    lookup("pre_reset", 8'h05, 1'b1, 8'h22);
    #2 rst_ = 1'b0;
    #1;
    $display("async reset found=%0b data=%02h", found_it, data);
    check("async_found", 32'(found_it), 32'd0);
    check("async_data", 32'(data), 32'd0);
    #2 rst_ = 1'b1;

    lookup("post_rst05", 8'h05, 1'b0, 8'h00);
    lookup("post_rst0a", 8'h0A, 1'b0, 8'h00);
    lookup("post_rst09", 8'h09, 1'b0, 8'h00);
    lookup("post_rst00", 8'h00, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
